// File: rtl/tdc_interval_assembler.sv
// -----------------------------------------------------------------------------
// tdc_interval_assembler
//
// Consumes the {code, wrena} write streams of a head and a tail fine counter,
// counts coarse clock cycles between the two strobes and merges coarse and fine
// parts into one signed interval in fine-tick units. Each result is pushed,
// together with status flags, into a small FIFO that the readout logic drains
// with a valid/ready handshake.
//
// Ports:
//   clk         system clock, everything on the rising edge
//   rst         synchronous active-high reset
//   head_code   fine code from the head counter, valid with head_wrena
//   head_wrena  head counter write strobe
//   tail_code   fine code from the tail counter, valid with tail_wrena
//   tail_wrena  tail counter write strobe
//   out_data    signed interval of the FIFO head entry (0 when empty)
//   out_flags   {overflow, range_err, restart} of the FIFO head entry
//   out_valid   FIFO holds at least one record
//   out_ready   consumer accepts the head entry when out_valid is high
//   drop_cnt    saturating count of records lost to a full FIFO
// -----------------------------------------------------------------------------
module tdc_interval_assembler #(
  parameter int CODE_W          = 6,
  parameter int COARSE_W        = 16,
  parameter int FINE_PER_COARSE = 40,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CODE_W-1:0]            head_code,
  input  logic                         head_wrena,
  input  logic [CODE_W-1:0]            tail_code,
  input  logic                         tail_wrena,
  output logic [COARSE_W+CODE_W+1:0]   out_data,
  output logic [2:0]                   out_flags,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   drop_cnt
);

  localparam int RES_W = COARSE_W + CODE_W + 2;
  localparam int ENT_W = RES_W + 3;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Last coarse value before the counter would saturate; reaching it ends
  // the measurement with an overflow record.
  localparam logic [COARSE_W-1:0] COARSE_TIMEOUT = {{(COARSE_W-1){1'b1}}, 1'b0};
  localparam logic [CODE_W:0]     FPC_CODE       = (CODE_W+1)'(FINE_PER_COARSE);
  localparam logic [CNT_W-1:0]    FIFO_FULL      = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TAIL = 2'd1,
    ST_COMPUTE   = 2'd2
  } state_t;

  // Interval = coarse * FINE_PER_COARSE + (tail + 1) - head. The tail counter
  // reports n-1, hence the +1. The product cannot overflow RES_W because the
  // multiplier is below 2^CODE_W.
  function automatic logic [RES_W-1:0] calc_interval(
    input logic [COARSE_W-1:0] lat,
    input logic [CODE_W-1:0]   hc,
    input logic [CODE_W-1:0]   tc
  );
    logic [RES_W-1:0] prod;
    prod = RES_W'(lat) * RES_W'(FINE_PER_COARSE);
    return prod + RES_W'(tc) + RES_W'(1'b1) - RES_W'(hc);
  endfunction

  // Code outside the valid fine range 0..FINE_PER_COARSE-1.
  function automatic logic code_out_of_range(input logic [CODE_W-1:0] code);
    return ({1'b0, code} >= FPC_CODE);
  endfunction

  // ---------------------------------------------------------------------------
  // Measurement FSM
  // ---------------------------------------------------------------------------
  state_t                state_r, state_s;
  logic [COARSE_W-1:0]   coarse_r, coarse_s;
  logic [COARSE_W-1:0]   coarse_lat_r, coarse_lat_s;
  logic [CODE_W-1:0]     head_code_r, head_code_s;
  logic [CODE_W-1:0]     tail_code_r, tail_code_s;
  logic                  restart_r, restart_s;
  logic                  push_s;
  logic [RES_W-1:0]      push_data_s;
  logic [2:0]            push_flags_s;

  // FSM and measurement registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      coarse_r     <= '0;
      coarse_lat_r <= '0;
      head_code_r  <= '0;
      tail_code_r  <= '0;
      restart_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      coarse_r     <= coarse_s;
      coarse_lat_r <= coarse_lat_s;
      head_code_r  <= head_code_s;
      tail_code_r  <= tail_code_s;
      restart_r    <= restart_s;
    end
  end

  // Next-state logic and record generation.
  always_comb begin
    state_s      = state_r;
    coarse_s     = coarse_r;
    coarse_lat_s = coarse_lat_r;
    head_code_s  = head_code_r;
    tail_code_s  = tail_code_r;
    restart_s    = restart_r;
    push_s       = 1'b0;
    push_data_s  = '0;
    push_flags_s = 3'b000;

    case (state_r)
      ST_IDLE: begin
        // A tail strobe here has no matching head and is ignored.
        if (head_wrena) begin
          head_code_s = head_code;
          coarse_s    = '0;
          state_s     = ST_WAIT_TAIL;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_WAIT_TAIL: begin
        coarse_s = coarse_r + COARSE_W'(1'b1);
        if (tail_wrena) begin
          // Tail wins over a simultaneous head strobe.
          tail_code_s  = tail_code;
          coarse_lat_s = coarse_r + COARSE_W'(1'b1);
          state_s      = ST_COMPUTE;
        end else if (head_wrena) begin
          head_code_s = head_code;
          coarse_s    = '0;
          restart_s   = 1'b1;
          state_s     = ST_WAIT_TAIL;
        end else if (coarse_r == COARSE_TIMEOUT) begin
          push_s       = 1'b1;
          push_data_s  = '1;
          push_flags_s = {1'b1, 1'b0, restart_r};
          restart_s    = 1'b0;
          state_s      = ST_IDLE;
        end else begin
          state_s = ST_WAIT_TAIL;
        end
      end

      ST_COMPUTE: begin
        // Strobes in this cycle are ignored.
        push_s       = 1'b1;
        push_data_s  = calc_interval(coarse_lat_r, head_code_r, tail_code_r);
        push_flags_s = {1'b0,
                        code_out_of_range(head_code_r) | code_out_of_range(tail_code_r),
                        restart_r};
        restart_s    = 1'b0;
        state_s      = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0]  mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, wr_ptr_s;
  logic [PTR_W-1:0]  rd_ptr_r, rd_ptr_s;
  logic [CNT_W-1:0]  count_r, count_s;
  logic [7:0]        drop_cnt_r;
  logic              pop_s;
  logic              full_s;
  logic              accept_s;
  logic              drop_s;
  logic [ENT_W-1:0]  push_ent_s;
  logic [ENT_W-1:0]  head_ent_s;

  // FIFO pointer/occupancy update and next head entry.
  always_comb begin
    push_ent_s = {push_flags_s, push_data_s};
    pop_s      = (count_r != '0) && out_ready;
    full_s     = (count_r == FIFO_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    accept_s   = push_s && (!full_s || pop_s);
    drop_s     = push_s && full_s && !pop_s;

    if (pop_s) begin
      rd_ptr_s = rd_ptr_r + PTR_W'(1'b1);
    end else begin
      rd_ptr_s = rd_ptr_r;
    end

    if (accept_s) begin
      wr_ptr_s = wr_ptr_r + PTR_W'(1'b1);
    end else begin
      wr_ptr_s = wr_ptr_r;
    end

    case ({accept_s, pop_s})
      2'b10:   count_s = count_r + CNT_W'(1'b1);
      2'b01:   count_s = count_r - CNT_W'(1'b1);
      default: count_s = count_r;
    endcase

    // The new head is the record being written when it lands in the slot
    // the read pointer moves to; otherwise it is already in storage.
    if (count_s == '0) begin
      head_ent_s = '0;
    end else if (accept_s && (rd_ptr_s == wr_ptr_r)) begin
      head_ent_s = push_ent_s;
    end else begin
      head_ent_s = mem_r[rd_ptr_s];
    end
  end

  // FIFO storage, pointers, drop counter and registered head outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      drop_cnt_r <= 8'd0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_flags  <= 3'b000;
    end else begin
      if (accept_s) begin
        mem_r[wr_ptr_r] <= push_ent_s;
      end
      wr_ptr_r <= wr_ptr_s;
      rd_ptr_r <= rd_ptr_s;
      count_r  <= count_s;
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
      out_valid <= (count_s != '0);
      out_data  <= head_ent_s[RES_W-1:0];
      out_flags <= head_ent_s[ENT_W-1:RES_W];
    end
  end

  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_tdc_interval_assembler.sv
// -----------------------------------------------------------------------------
// Self-checking bench for tdc_interval_assembler (COARSE_W=4 so timeouts are
// reachable). The reference model works on cycle timestamps: an interval is
// simply tail_cycle - head_cycle, a timeout is 15 cycles after the last head,
// and the FIFO is a pair of queues.
// -----------------------------------------------------------------------------
module tb_tdc_interval_assembler;

  localparam int CW    = 6;
  localparam int KW    = 4;
  localparam int FPC   = 40;
  localparam int DEPTH = 4;
  localparam int RW    = KW + CW + 2;
  localparam int TMO   = (1 << KW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] head_code = '0;
  logic          head_wrena = 1'b0;
  logic [CW-1:0] tail_code = '0;
  logic          tail_wrena = 1'b0;
  logic [RW-1:0] out_data;
  logic [2:0]    out_flags;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [7:0]    drop_cnt;

  tdc_interval_assembler #(
    .CODE_W(CW), .COARSE_W(KW), .FINE_PER_COARSE(FPC), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .head_code(head_code), .head_wrena(head_wrena),
    .tail_code(tail_code), .tail_wrena(tail_wrena),
    .out_data(out_data), .out_flags(out_flags), .out_valid(out_valid),
    .out_ready(out_ready), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit live   = 1'b0;

  // Reference model state
  logic [RW-1:0] qd[$];
  logic [2:0]    qf[$];
  int            m_drop;
  bit            m_active;
  int            m_head_cyc;
  int            m_head_code;
  bit            m_restart;
  bit            m_pend;
  logic [RW-1:0] m_pend_data;
  bit            m_pend_rerr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] model_front_data();
    if (qd.size() > 0) return qd[0];
    return '0;
  endfunction

  function automatic logic [2:0] model_front_flags();
    if (qf.size() > 0) return qf[0];
    return 3'b000;
  endfunction

  task automatic model_step(input bit h, input int hc, input bit t, input int tc,
                            input bit rdy, input bit r);
    bit            push;
    logic [RW-1:0] pd;
    logic [2:0]    pf;
    int            lat;
    push = 1'b0;
    pd   = '0;
    pf   = 3'b000;
    if (r) begin
      qd.delete();
      qf.delete();
      m_drop    = 0;
      m_active  = 1'b0;
      m_restart = 1'b0;
      m_pend    = 1'b0;
    end else begin
      if (m_pend) begin
        push      = 1'b1;
        pd        = m_pend_data;
        pf        = {1'b0, m_pend_rerr, m_restart};
        m_restart = 1'b0;
        m_pend    = 1'b0;
      end else if (m_active) begin
        if (t) begin
          lat         = cyc - m_head_cyc;
          m_pend_data = RW'(lat * FPC + tc + 1 - m_head_code);
          m_pend_rerr = (m_head_code >= FPC) || (tc >= FPC);
          m_pend      = 1'b1;
          m_active    = 1'b0;
        end else if (h) begin
          m_head_cyc  = cyc;
          m_head_code = hc;
          m_restart   = 1'b1;
        end else if (cyc - m_head_cyc == TMO) begin
          push      = 1'b1;
          pd        = '1;
          pf        = {1'b1, 1'b0, m_restart};
          m_restart = 1'b0;
          m_active  = 1'b0;
        end
      end else if (h) begin
        m_active    = 1'b1;
        m_head_cyc  = cyc;
        m_head_code = hc;
      end
      if (qd.size() > 0 && rdy) begin
        void'(qd.pop_front());
        void'(qf.pop_front());
      end
      if (push) begin
        if (qd.size() < DEPTH) begin
          qd.push_back(pd);
          qf.push_back(pf);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, let the DUT and model consume it.
  task automatic step(input int h, input int hc, input int t, input int tc,
                      input int rdy, input int r);
    head_wrena = (h != 0);
    head_code  = CW'(hc);
    tail_wrena = (t != 0);
    tail_code  = CW'(tc);
    out_ready  = (rdy != 0);
    rst        = (r != 0);
    @(posedge clk);
    model_step(h != 0, hc, t != 0, tc, rdy != 0, r != 0);
    cyc++;
    live = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (live) begin
      chk("out_valid", 32'(out_valid), 32'(qd.size() > 0));
      chk("out_data",  32'(out_data),  32'(model_front_data()));
      chk("out_flags", 32'(out_flags), 32'(model_front_flags()));
      chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
    end
  end

  initial begin
    int exp_seq[4];
    int rdy_th;

    // Reset
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_flags", 32'(out_flags), 32'd0);
    chk("rst_drop",  32'(drop_cnt),  32'd0);
    idle(1);

    // Basic: head 10, tail 5 three cycles later -> 3*40+6-10 = 116
    step(1, 10, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 5, 0, 0);
    chk("basic_latency", 32'(out_valid), 32'd0);
    idle(1);
    chk("basic_valid", 32'(out_valid), 32'd1);
    chk("basic_data",  32'(out_data),  32'd116);
    chk("basic_model", 32'(model_front_data()), 32'd116);
    chk("basic_flags", 32'(out_flags), 32'd0);
    step(0, 0, 0, 0, 1, 0);
    chk("basic_popped", 32'(out_valid), 32'd0);

    // Restart: head 7, head 20 two later, tail 0 two later -> 61, restart
    step(1, 7, 0, 0, 0, 0);
    idle(1);
    step(1, 20, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 1, 0, 0, 0);
    idle(1);
    chk("restart_data",  32'(out_data),  32'd61);
    chk("restart_model", 32'(model_front_data()), 32'd61);
    chk("restart_flags", 32'(out_flags), 32'b001);
    step(1, 5, 0, 0, 1, 0);
    step(0, 0, 1, 5, 0, 0);
    idle(1);
    chk("after_restart_data",  32'(out_data),  32'd41);
    chk("after_restart_flags", 32'(out_flags), 32'b000);
    step(0, 0, 0, 0, 1, 0);

    // Lone tail in IDLE is ignored; head+tail together starts a measurement
    step(0, 0, 1, 7, 0, 0);
    idle(3);
    chk("lone_tail", 32'(out_valid), 32'd0);
    step(1, 9, 1, 3, 0, 0);
    idle(1);
    step(0, 0, 1, 3, 0, 0);
    idle(1);
    chk("simul_data", 32'(out_data), 32'd75);
    step(0, 0, 0, 0, 1, 0);

    // Timeout after 15 cycles without a tail
    step(1, 12, 0, 0, 0, 0);
    idle(TMO - 1);
    chk("timeout_early", 32'(out_valid), 32'd0);
    idle(1);
    chk("timeout_valid", 32'(out_valid), 32'd1);
    chk("timeout_data",  32'(out_data),  32'hFFF);
    chk("timeout_model", 32'(model_front_data()), 32'hFFF);
    chk("timeout_flags", 32'(out_flags), 32'b100);
    step(1, 1, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0, 0);
    idle(1);
    chk("post_timeout_data", 32'(out_data), 32'd41);
    step(0, 0, 0, 0, 1, 0);

    // Backpressure: six records into a four-deep FIFO
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, i, 0, 0);
      idle(1);
    end
    chk("bp_drop",       32'(drop_cnt), 32'd2);
    chk("bp_model_drop", 32'(m_drop),   32'd2);
    chk("bp_head",       32'(out_data), 32'd41);
    // Full FIFO with pop and push in the same cycle: no drop
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 6, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("bp_pushpop_drop", 32'(drop_cnt), 32'd2);
    exp_seq = '{42, 43, 44, 47};
    for (int j = 0; j < 4; j++) begin
      chk("bp_order", 32'(out_data), 32'(exp_seq[j]));
      step(0, 0, 0, 0, 1, 0);
    end
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset in WAIT_TAIL with two records queued
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 1, i + 1, 0, 0);
      idle(1);
    end
    step(1, 3, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_drop",  32'(drop_cnt),  32'd0);
    step(0, 0, 1, 5, 0, 0);
    idle(3);
    chk("midrst_no_record", 32'(out_valid), 32'd0);

    // Randomized traffic: low then high drain rate
    for (int i = 0; i < 4000; i++) begin
      rdy_th = (i < 2000) ? 1 : 3;
      step(int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 63)),
           int'($urandom_range(0, 5) == 0), int'($urandom_range(0, 63)),
           int'($urandom_range(0, 3) < rdy_th), int'($urandom_range(0, 299) == 0));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
